// File: rtl/tdm_mux81.sv
// Time-division 8-to-1 multiplexer: snapshots eight channel bits on start and
// serialises them slot by slot with the slot index driven alongside.
module tdm_mux81 #(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic start,
    input  logic cont,
    output logic out,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic valid,
    output logic frame,
    output logic busy,
    output logic done
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] hold_q, hold_d;
    logic       out_q, out_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic       frame_q, frame_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] din;
    logic [2:0] slot_inc;

    assign din      = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign slot_inc = slot_q + 3'd1;

    // Output registers always describe the slot that is live after the edge,
    // so every branch computes the outputs for the next cycle's slot.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        slot_d   = slot_q;
        hold_d   = hold_q;
        out_d    = 1'b0;
        sel_d    = 3'd0;
        valid_d  = 1'b0;
        frame_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // A start on the done cycle is dropped, not queued.
                if (start && !done_q) begin
                    state_d  = SEND;
                    shadow_d = din;
                    slot_d   = 3'd0;
                    hold_d   = 8'd0;
                    out_d    = din[0];
                    valid_d  = 1'b1;
                    frame_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SEND: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d  = hold_q + 8'd1;
                    out_d   = shadow_q[slot_q];
                    sel_d   = slot_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (slot_q != 3'd7) begin
                    hold_d  = 8'd0;
                    slot_d  = slot_inc;
                    out_d   = shadow_q[slot_inc];
                    sel_d   = slot_inc;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (cont) begin
                    hold_d   = 8'd0;
                    slot_d   = 3'd0;
                    shadow_d = din;
                    out_d    = din[0];
                    valid_d  = 1'b1;
                    frame_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    hold_d  = 8'd0;
                    slot_d  = 3'd0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= 8'd0;
            slot_q   <= 3'd0;
            hold_q   <= 8'd0;
            out_q    <= 1'b0;
            sel_q    <= 3'd0;
            valid_q  <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            slot_q   <= slot_d;
            hold_q   <= hold_d;
            out_q    <= out_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out   = out_q;
    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign s2    = sel_q[2];
    assign valid = valid_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/tdm_mux81.md
Name: tdm_mux81

Overview:
- Time-division 8-to-1 multiplexer; the transmit end of the 1-to-8 demux path.
- On a start request it snapshots eight 1-bit channels and drives them one slot at a time onto a single serial line.
- It drives the 3-bit select code s2..s0 alongside the data, so a downstream 1-to-8 demux can route each bit back to its channel.
- Sits between the channel sources and the serial link/demux.

Parameters:
- HOLD, 1, clock cycles each slot is held on the line (legal 1..256; internal hold counter is 8 bits).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- d0..d7  input  1 each  channel data, sampled only at frame capture.
- start  input  1  request one frame; sampled on rising clk.
- cont  input  1  continuous mode; sampled at the end of slot 7.
- out  output  1  serial data for the current slot.
- s0, s1, s2  output  1 each  current slot index, s2 = MSB.
- valid  output  1  out/s2..s0 carry a live slot.
- frame  output  1  high only during the first cycle of slot 0.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse after a non-continuous frame ends.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Reset (async assert) forces out, s0, s1, s2, valid, frame, busy and done to 0.
- Reset also clears the shadow register, the slot counter and the hold counter, and puts the FSM in IDLE. The reset is released synchronously to clk.
- Reset mid-frame aborts the frame immediately with no done pulse.
- FSM states: IDLE, SEND.
- IDLE:
  - valid = busy = frame = 0, out = 0, s2..s0 = 000.
  - start = 1 at edge k: capture d7..d0 into the shadow register, slot = 0, hold = 0, go to SEND.
  - After edge k: valid = 1, busy = 1, frame = 1, s2..s0 = 000, out = shadow[0].
  - Start-to-first-slot latency is therefore one edge.
- SEND:
  - out = shadow[slot], {s2,s1,s0} = slot, valid = 1, busy = 1.
  - The hold counter increments every cycle. When hold = HOLD-1, the slot advances and hold returns to 0. frame deasserts after the first cycle.
  - At the last cycle of slot 7:
    - cont = 1: recapture d7..d0, slot wraps 7 -> 0, frame = 1 on the next cycle. No gap cycle; busy stays 1; no done pulse.
    - cont = 0: go to IDLE. On that next cycle done = 1, valid = 0, busy = 0, out = 0, s2..s0 = 000. done drops the following cycle.
- start while busy = 1 is ignored and not queued.
- start = 1 on the same edge as an IDLE return (the done cycle) is also ignored. A new frame requires start sampled while busy = 0 and done = 0.
- d0..d7 changes during SEND have no effect until the next capture.
- Frame length is exactly 8*HOLD cycles. Slot order is always 0,1,...,7.
- With HOLD = 1, frame and the slot-0 cycle coincide.

Test Plan:
- Reset: assert rst mid-frame at slot 3 -> same cycle (async): out = 0, s2..s0 = 000, valid = 0, busy = 0, done = 0. After release, idle until start.
- Single frame, HOLD = 1:
  - Stimulus: d7..d0 = 8'b1011_0010, pulse start.
  - Required: 8 consecutive cycles with s = 0..7 and out = 0,1,0,0,1,1,0,1; frame = 1 only on slot 0.
  - Then one cycle with done = 1 and busy = 0.
- HOLD = 3, d = 8'hFF: each s value is held exactly 3 cycles; the frame lasts 24 cycles with busy = 1 throughout; one done pulse follows.
- Continuous mode:
  - Stimulus: cont = 1, first frame d = 8'h0F; change d to 8'hF0 during slot 5.
  - Required: the second frame starts with no gap and carries out = 0,0,0,0,1,1,1,1. No done until cont = 0 at the end of slot 7, then exactly one done pulse.
- Ignored start: pulse start during slot 4 and on the done cycle -> frame timing is unchanged and no extra frame begins. A start two cycles after done begins a new frame.
- Input isolation: toggle d3 every cycle during SEND -> out in slot 3 equals the value of d3 captured at start.
- Loopback check: feed out/s2..s0 (qualified by valid) into a 1-to-8 demux. Each demux output reproduces its captured channel bit during its own slot and is 0 in all other slots.
